cascade_mod_counter: RTL and testbench
======================================

Name: cascade_mod_counter

Overview:
Multi-digit modulo counter built from DIGITS cascaded digits, each counting modulo MODULUS. It replaces single fixed-limit counters in timer and sequencer datapaths. Added capabilities: up/down counting, synchronous parallel load with digit validation, a one-cycle wrap pulse and a sticky overflow flag. Typical use is a BCD event or time counter (MODULUS=10) or a mixed-radix tick divider.

Parameters:
DIGITS, 4, number of cascaded digits (>=1).
DIGIT_W, 4, bits per digit; MODULUS <= 2**DIGIT_W is required.
MODULUS, 10, per-digit modulus (>=2); each digit counts 0..MODULUS-1.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  reset, synchronous, active-high.
clockinh  input  1  count inhibit, active-high; holds the count.
up_down  input  1  1 = count up, 0 = count down; sampled each enabled edge.
load  input  1  synchronous parallel load strobe.
load_value  input  DIGITS*DIGIT_W  load data; digit k occupies bits [k*DIGIT_W +: DIGIT_W], and digit 0 is least significant.
clear_ovf  input  1  clears the sticky overflow flag.
count  output  DIGITS*DIGIT_W  current count, using the same digit packing as load_value.
carryout  output  1  one-cycle pulse when the whole counter wraps.
overflow  output  1  sticky flag; set on any wrap.
load_err  output  1  one-cycle pulse when a loaded digit was out of range.

Behaviour:
- All outputs are registered and update on the rising edge of clock.
- Reset values: count=0, carryout=0, overflow=0, load_err=0.
- Per-edge priority: reset > load > clockinh > count step.
- reset: forces all reset values, regardless of load, clockinh or clear_ovf.
- load:
  - Each digit takes load_value[k]. A digit >= MODULUS is stored as MODULUS-1 instead.
  - load_err=1 for the next cycle if any digit was clamped; otherwise 0.
  - carryout=0. A load never steps the count, even when clockinh=0.
- clockinh=1 with load=0: count holds and carryout=0.
- Count step (clockinh=0, load=0, reset=0):
  - Up: digit 0 increments. A digit at MODULUS-1 becomes 0 and ripples a carry to the next digit in the same cycle.
  - Down: digit 0 decrements. A digit at 0 becomes MODULUS-1 and ripples a borrow.
  - All rippling is combinational within one edge; each step has single-cycle latency.
- Wrap:
  - A wrap occurs when the carry or borrow exits the top digit.
  - Up wrap: all digits MODULUS-1 -> all 0.
  - Down wrap: all 0 -> all MODULUS-1.
  - On the wrap edge, carryout=1 for exactly one cycle, coincident with the wrapped count. It is 0 on every other cycle.
- overflow:
  - Set on the wrap edge.
  - Otherwise cleared by clear_ovf=1.
  - If a wrap and clear_ovf occur on the same edge, the set wins.
  - Load does not affect overflow.
- load_err is 0 on every edge without a load.
- Direction change: up_down may change on any cycle. Each edge uses its current value, and no state is carried between edges apart from count.
- Reset mid-operation: applying reset on any edge, including a wrap edge, gives count=0 and carryout=0 on the next cycle.
- Loaded digit values are never outside 0..MODULUS-1, so count is always a valid mixed-radix value.
- DIGITS=1 is legal: the counter is a plain modulo-MODULUS counter with a wrap pulse.

Test Plan:
(All scenarios use DIGITS=2, DIGIT_W=4, MODULUS=10.)
1. Reset -> count=0x00, carryout=0, overflow=0, load_err=0. Assert reset together with load=1, load_value=0x55 -> count=0x00.
2. From 0x00, up_down=1, clockinh=0 for 99 edges -> count=0x99, carryout=0 throughout, including 0x09->0x10 and 0x19->0x20. Edge 100 -> count=0x00, carryout=1 for one cycle, overflow=1. Edge 101 -> count=0x01, carryout=0, overflow still 1.
3. Load 0x00, then up_down=0 and one edge -> count=0x99, carryout=1, overflow=1. Next edge -> 0x98. Then clear_ovf=1 for one edge -> overflow=0.
4. clockinh=1 for 5 edges at 0x42 -> count stays 0x42. With clockinh=1, pulse load with load_value=0x17 -> count=0x17 (load beats inhibit).
5. Load 0x3C -> count=0x39, load_err=1 for one cycle. Load 0xF0 -> count=0x90, load_err=1. Load 0x25 -> count=0x25, load_err=0.
6. At 0x99 counting up, assert clear_ovf on the wrap edge -> overflow=1 (set wins). At 0x99, assert reset on the wrap edge -> count=0x00, carryout=0, overflow=0.

Source files
------------

// File: rtl/cascade_mod_counter.sv
// Cascaded mixed-radix counter: DIGITS digits, each counting modulo MODULUS, with up/down count, load with clamping, wrap pulse and sticky overflow.
// Latency: one cycle; count, carryout, overflow and load_err are all registered and update together on each edge.
// Backpressure: none; clockinh holds the count, and load takes priority over clockinh.
module cascade_mod_counter #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4,
    parameter int MODULUS = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clockinh,
    input  logic                       up_down,
    input  logic                       load,
    input  logic [DIGITS*DIGIT_W-1:0]  load_value,
    input  logic                       clear_ovf,
    output logic [DIGITS*DIGIT_W-1:0]  count,
    output logic                       carryout,
    output logic                       overflow,
    output logic                       load_err
);

    localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(MODULUS - 1);

    logic [DIGITS*DIGIT_W-1:0] step_value;
    logic [DIGITS*DIGIT_W-1:0] clamped_value;
    logic                      step_wrap;
    logic                      clamp_any;
    logic                      ripple;
    logic [DIGIT_W-1:0]        digit;
    logic [DIGIT_W-1:0]        ld_digit;

    // Carry/borrow ripples through every digit within the same cycle.
    always_comb begin
        step_value = count;
        ripple     = 1'b1;
        digit      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            digit = count[k*DIGIT_W +: DIGIT_W];
            if (ripple) begin
                if (up_down) begin
                    if (digit == MAX_DIGIT) begin
                        step_value[k*DIGIT_W +: DIGIT_W] = '0;
                    end else begin
                        step_value[k*DIGIT_W +: DIGIT_W] = digit + 1'b1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (digit == '0) begin
                        step_value[k*DIGIT_W +: DIGIT_W] = MAX_DIGIT;
                    end else begin
                        step_value[k*DIGIT_W +: DIGIT_W] = digit - 1'b1;
                        ripple = 1'b0;
                    end
                end
            end
        end
        step_wrap = ripple;
    end

    always_comb begin
        clamped_value = load_value;
        clamp_any     = 1'b0;
        ld_digit      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            ld_digit = load_value[k*DIGIT_W +: DIGIT_W];
            if (32'(ld_digit) >= MODULUS) begin
                clamped_value[k*DIGIT_W +: DIGIT_W] = MAX_DIGIT;
                clamp_any = 1'b1;
            end
        end
    end

    // A wrap and clear_ovf on the same edge leave overflow set.
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            count    <= clamped_value;
            carryout <= 1'b0;
            overflow <= overflow & ~clear_ovf;
            load_err <= clamp_any;
        end else if (clockinh) begin
            carryout <= 1'b0;
            overflow <= overflow & ~clear_ovf;
            load_err <= 1'b0;
        end else begin
            count    <= step_value;
            carryout <= step_wrap;
            overflow <= step_wrap | (overflow & ~clear_ovf);
            load_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cascade_mod_counter.sv
// Bench for cascade_mod_counter (2 BCD digits): directed scenarios followed by random stimulus,
// all checked against an integer-valued model of the counter.
module tb_cascade_mod_counter;

    logic       clock = 1'b0;
    logic       reset;
    logic       clockinh;
    logic       up_down;
    logic       load;
    logic [7:0] load_value;
    logic       clear_ovf;
    logic [7:0] count;
    logic       carryout;
    logic       overflow;
    logic       load_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: the counter value as a plain integer 0..99.
    int m_val  = 0;
    bit m_cout = 0;
    bit m_ovf  = 0;
    bit m_lerr = 0;

    cascade_mod_counter #(.DIGITS(2), .DIGIT_W(4), .MODULUS(10)) dut (
        .clock      (clock),
        .reset      (reset),
        .clockinh   (clockinh),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .clear_ovf  (clear_ovf),
        .count      (count),
        .carryout   (carryout),
        .overflow   (overflow),
        .load_err   (load_err)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit ld, input logic [7:0] lv,
                              input bit inh, input bit ud, input bit clr);
        int  hi;
        int  lo;
        bit  wrap;
        if (rst) begin
            m_val = 0; m_cout = 0; m_ovf = 0; m_lerr = 0;
        end else if (ld) begin
            hi = int'(lv[7:4]);
            lo = int'(lv[3:0]);
            m_lerr = (hi > 9) || (lo > 9);
            if (hi > 9) hi = 9;
            if (lo > 9) lo = 9;
            m_val  = hi * 10 + lo;
            m_cout = 0;
            m_ovf  = m_ovf && !clr;
        end else if (inh) begin
            m_cout = 0; m_lerr = 0;
            m_ovf  = m_ovf && !clr;
        end else begin
            wrap   = ud ? (m_val == 99) : (m_val == 0);
            m_val  = ud ? (m_val + 1) % 100 : (m_val + 99) % 100;
            m_cout = wrap;
            m_ovf  = wrap || (m_ovf && !clr);
            m_lerr = 0;
        end
    endtask

    task automatic cycle(input bit rst, input bit ld, input logic [7:0] lv,
                         input bit inh, input bit ud, input bit clr);
        reset = rst; load = ld; load_value = lv;
        clockinh = inh; up_down = ud; clear_ovf = clr;
        @(posedge clock);
        model_edge(rst, ld, lv, inh, ud, clr);
        #1;
        check("count",    32'(count),    32'(to_bcd(m_val)));
        check("carryout", 32'(carryout), 32'(m_cout));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("load_err", 32'(load_err), 32'(m_lerr));
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_value = '0;
        clockinh = 1'b0; up_down = 1'b1; clear_ovf = 1'b0;

        // Reset, with load asserted at the same time
        cycle(1, 1, 8'h55, 0, 1, 0);
        check("rst_count", 32'(count), 32'h00);

        // Count up through every value to the wrap
        for (int i = 0; i < 99; i++) cycle(0, 0, 8'h00, 0, 1, 0);
        check("up99_count", 32'(count), 32'h99);
        cycle(0, 0, 8'h00, 0, 1, 0);
        check("upwrap_count", 32'(count), 32'h00);
        check("upwrap_cout",  32'(carryout), 32'h1);
        cycle(0, 0, 8'h00, 0, 1, 0);
        check("after_wrap_cout", 32'(carryout), 32'h0);
        check("after_wrap_ovf",  32'(overflow), 32'h1);

        // Count down through the wrap, then clear overflow
        cycle(0, 1, 8'h00, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 0, 0);
        check("downwrap_count", 32'(count), 32'h99);
        check("downwrap_cout",  32'(carryout), 32'h1);
        cycle(0, 0, 8'h00, 0, 0, 0);
        check("down_98", 32'(count), 32'h98);
        cycle(0, 0, 8'h00, 1, 0, 1);
        check("clear_ovf", 32'(overflow), 32'h0);

        // Inhibit holds the count; load takes priority over inhibit
        cycle(0, 1, 8'h42, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 1, 1, 0);
        check("inh_hold", 32'(count), 32'h42);
        cycle(0, 1, 8'h17, 1, 1, 0);
        check("load_over_inh", 32'(count), 32'h17);

        // Loads with out-of-range digits are clamped
        cycle(0, 1, 8'h3C, 0, 1, 0);
        check("clamp_lo", 32'(count), 32'h39);
        check("clamp_lo_err", 32'(load_err), 32'h1);
        cycle(0, 1, 8'hF0, 0, 1, 0);
        check("clamp_hi", 32'(count), 32'h90);
        cycle(0, 1, 8'h25, 0, 1, 0);
        check("load_ok_err", 32'(load_err), 32'h0);
        cycle(0, 0, 8'h00, 1, 1, 0);

        // Wrap and clear_ovf on the same edge; reset on a wrap edge
        cycle(0, 1, 8'h99, 0, 1, 0);
        cycle(0, 0, 8'h00, 0, 1, 1);
        check("wrap_beats_clr", 32'(overflow), 32'h1);
        cycle(0, 1, 8'h99, 0, 1, 0);
        cycle(1, 0, 8'h00, 0, 1, 0);
        check("rst_on_wrap_count", 32'(count), 32'h00);
        check("rst_on_wrap_cout",  32'(carryout), 32'h0);

        // Random stimulus
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(99) < 2,
                  $urandom_range(99) < 10,
                  8'($urandom),
                  $urandom_range(99) < 25,
                  1'($urandom),
                  $urandom_range(99) < 10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
